// File: rtl/dmem_wait_ctrl.sv
// Data-memory controller with a fixed number of wait cycles per access.
// Handles byte/half/word loads and stores with alignment checks and load extension.
module dmem_wait_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  s_type,
    input  logic [2:0]  l_type,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        rsp_valid,
    output logic [31:0] mem_rdata,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [3:0] LAT_M1  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rd_word_q;
    logic [31:0] mem_array [DEPTH_WORDS];

    logic        accept, do_access, use_in;
    logic        cur_we, cur_err, wr_ok, is_sb, is_sh, is_sw;
    logic [2:0]  cur_type;
    logic [31:0] cur_addr, cur_wdata;
    logic [AW-1:0] idx;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;

    function automatic logic acc_err(input logic we, input logic [2:0] ty, input logic [1:0] a);
        logic e;
        e = 1'b1;
        if (we) begin
            case (ty)
                3'b000:  e = 1'b0;
                3'b001:  e = a[0];
                3'b010:  e = |a;
                default: e = 1'b1;
            endcase
        end else begin
            case (ty)
                3'b000, 3'b100: e = 1'b0;
                3'b001, 3'b101: e = a[0];
                3'b010:         e = |a;
                default:        e = 1'b1;
            endcase
        end
        return e;
    endfunction

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready && reset;

    // With zero latency the access happens on the acceptance edge, so it uses the live inputs.
    assign use_in    = (state_q == ST_IDLE);
    assign cur_we    = use_in ? req_we    : we_q;
    assign cur_type  = use_in ? (req_we ? s_type : l_type) : type_q;
    assign cur_addr  = use_in ? mem_addr  : addr_q;
    assign cur_wdata = use_in ? mem_wdata : wdata_q;
    assign cur_err   = acc_err(cur_we, cur_type, cur_addr[1:0]);
    assign idx       = cur_addr[AW+1:2];

    assign do_access = reset && ((accept && (LATENCY == 0)) ||
                                 ((state_q == ST_WAIT) && (cnt_q == 4'd0)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        type_d  = type_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    type_d  = req_we ? s_type : l_type;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            type_q  <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign wr_ok = do_access && cur_we && !cur_err;
    assign is_sb = (cur_type == 3'b000);
    assign is_sh = (cur_type == 3'b001);
    assign is_sw = (cur_type == 3'b010);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign wr_be[gi] = wr_ok && (is_sw ||
                                         (is_sh && (cur_addr[1] == LANE[1])) ||
                                         (is_sb && (cur_addr[1:0] == LANE)));
            assign wr_data[8*gi +: 8] = is_sw ? cur_wdata[8*gi +: 8] :
                                        is_sh ? cur_wdata[8*(gi%2) +: 8] :
                                                cur_wdata[7:0];
        end
    endgenerate

    // Memory has no reset; the read captures the word before this edge's write lands.
    always_ff @(posedge clk) begin
        if (do_access) begin
            rd_word_q <= mem_array[idx];
        end
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                mem_array[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    logic        resp_err;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign rsp_valid = (state_q == ST_RESP);
    assign resp_err  = acc_err(we_q, type_q, addr_q[1:0]);
    assign sel_half  = addr_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];

    always_comb begin
        case (addr_q[1:0])
            2'd0:    sel_byte = rd_word_q[7:0];
            2'd1:    sel_byte = rd_word_q[15:8];
            2'd2:    sel_byte = rd_word_q[23:16];
            default: sel_byte = rd_word_q[31:24];
        endcase
    end

    always_comb begin
        mem_rdata = 32'd0;
        err       = 1'b0;
        if (rsp_valid) begin
            err = resp_err;
            if (!we_q && !resp_err) begin
                case (type_q)
                    3'b000:  mem_rdata = {{24{sel_byte[7]}}, sel_byte};
                    3'b100:  mem_rdata = {24'd0, sel_byte};
                    3'b001:  mem_rdata = {{16{sel_half[15]}}, sel_half};
                    3'b101:  mem_rdata = {16'd0, sel_half};
                    3'b010:  mem_rdata = rd_word_q;
                    default: mem_rdata = 32'd0;
                endcase
            end
        end
    end

endmodule
